uart_apb_reg_ctrl: RTL

//   APB-side register controller for the UART. Tracks the APB SETUP/ACCESS phases, decodes PADDR

---
 rtl/uart_apb_reg_ctrl.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_apb_reg_ctrl.sv
// ---------------------------------------------------------------------------
// uart_apb_reg_ctrl
//   APB register front end of the UART. Tracks the APB setup/access phases,
//   decodes PADDR into the UART register map, and drives push/pop strobes
//   towards the external TX and RX FIFOs (the RX FIFO is show-ahead).
//   It also holds the configuration registers (CTRL, baud divisor, IER),
//   the sticky overrun flags, and a registered interrupt.
//   Transfers complete with zero wait states.
//
// Ports
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE  APB control
//   PADDR[7:0]             register byte address
//   PWDATA[7:0]            write data
//   PRDATA[7:0]            read data (registered at the end of setup)
//   PREADY                 constant 1
//   PERROR                 transfer error, only during the access phase
//   tx_push, tx_data[7:0]  TX FIFO write strobe / data
//   tx_full, tx_empty      TX FIFO status
//   rx_pop                 RX FIFO pop strobe
//   rx_data[7:0]           RX FIFO head (show-ahead)
//   rx_empty, rx_full      RX FIFO status
//   rx_overrun             receiver dropped-byte pulse
//   ctrl[7:0]              {3'b0, stop2, parity[1:0], rx_en, tx_en}
//   baud_div[15:0]         {BAUD_HI, BAUD_LO}
//   irq                    registered interrupt request
// ---------------------------------------------------------------------------
module uart_apb_reg_ctrl #(
  parameter logic [15:0] BAUD_DIV_RST = 16'd27,
  parameter logic [7:0]  CTRL_RST     = 8'h00
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [7:0]  PWDATA,
  output logic [7:0]  PRDATA,
  output logic        PREADY,
  output logic        PERROR,
  output logic        tx_push,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  input  logic        tx_empty,
  output logic        rx_pop,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  input  logic        rx_full,
  input  logic        rx_overrun,
  output logic [7:0]  ctrl,
  output logic [15:0] baud_div,
  output logic        irq
);

  localparam logic [7:0] ADDR_DATA    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_IER     = 8'h0C;
  localparam logic [7:0] ADDR_BAUD_LO = 8'h10;
  localparam logic [7:0] ADDR_BAUD_HI = 8'h14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_prdata;
  logic        r_rx_avail;
  logic [7:0]  r_ctrl;
  logic [5:0]  r_ier;
  logic [7:0]  r_baud_lo;
  logic [7:0]  r_baud_hi;
  logic        r_tx_ovr;
  logic        r_rx_ovr;
  logic        r_irq;

  logic        w_setup_ph;
  logic        w_acc_ok;
  logic        w_proto_err;
  logic        w_wr_acc;
  logic        w_rd_acc;

  logic        w_sel_data;
  logic        w_sel_status;
  logic        w_sel_ctrl;
  logic        w_sel_ier;
  logic        w_sel_blo;
  logic        w_sel_bhi;
  logic        w_mapped;

  logic [7:0]  w_status;
  logic [7:0]  w_rd_mux;

  logic        w_push;
  logic        w_pop;
  logic        w_tx_ovr_set;
  logic        w_rd_empty_err;
  logic        w_xfer_err;
  logic        w_sts_wr;

  // -------------------------------------------------------------------------
  // FSM: state register
  // r_state records the APB phase of the previous cycle, so an access-phase
  // cycle is legal only when r_state is ST_SETUP.
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (PSEL && !PENABLE) w_state_nxt = ST_SETUP;
        else                  w_state_nxt = ST_IDLE;
      end
      ST_SETUP: begin
        if (PSEL && PENABLE)       w_state_nxt = ST_ACCESS;
        else if (PSEL && !PENABLE) w_state_nxt = ST_SETUP;  // restarted setup
        else                       w_state_nxt = ST_IDLE;   // aborted
      end
      ST_ACCESS: begin
        if (PSEL && !PENABLE) w_state_nxt = ST_SETUP;       // back-to-back
        else                  w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic (phase qualification)
  // -------------------------------------------------------------------------
  always_comb begin
    w_setup_ph  = PSEL & ~PENABLE;
    w_acc_ok    = 1'b0;
    w_proto_err = 1'b0;
    case (r_state)
      ST_SETUP: w_acc_ok    = PSEL & PENABLE;
      default:  w_proto_err = PSEL & PENABLE;  // access without a setup
    endcase
  end

  assign w_wr_acc = w_acc_ok &  PWRITE;
  assign w_rd_acc = w_acc_ok & ~PWRITE;

  // Address decode (APB keeps PADDR stable across setup and access).
  assign w_sel_data   = (PADDR == ADDR_DATA);
  assign w_sel_status = (PADDR == ADDR_STATUS);
  assign w_sel_ctrl   = (PADDR == ADDR_CTRL);
  assign w_sel_ier    = (PADDR == ADDR_IER);
  assign w_sel_blo    = (PADDR == ADDR_BAUD_LO);
  assign w_sel_bhi    = (PADDR == ADDR_BAUD_HI);
  assign w_mapped     = w_sel_data | w_sel_status | w_sel_ctrl |
                        w_sel_ier  | w_sel_blo    | w_sel_bhi;

  assign w_status = {2'b00, r_rx_ovr, r_tx_ovr, rx_full, rx_empty, tx_empty, tx_full};

  // Read data selected during setup; captured into PRDATA at the end of setup.
  always_comb begin
    w_rd_mux = 8'h00;
    if (!PWRITE) begin
      case (PADDR)
        ADDR_DATA:    w_rd_mux = rx_empty ? 8'h00 : rx_data;
        ADDR_STATUS:  w_rd_mux = w_status;
        ADDR_CTRL:    w_rd_mux = r_ctrl;
        ADDR_IER:     w_rd_mux = {2'b00, r_ier};
        ADDR_BAUD_LO: w_rd_mux = r_baud_lo;
        ADDR_BAUD_HI: w_rd_mux = r_baud_hi;
        default:      w_rd_mux = 8'h00;
      endcase
    end
  end

  // Access-phase strobes and error sources.
  assign w_push         = w_wr_acc & w_sel_data & ~tx_full;
  assign w_tx_ovr_set   = w_wr_acc & w_sel_data &  tx_full;
  // RX availability was latched at setup, so pop and error agree with PRDATA.
  assign w_pop          = w_rd_acc & w_sel_data &  r_rx_avail;
  assign w_rd_empty_err = w_rd_acc & w_sel_data & ~r_rx_avail;
  assign w_xfer_err     = (w_acc_ok & ~w_mapped) | w_tx_ovr_set | w_rd_empty_err;
  assign w_sts_wr       = w_wr_acc & w_sel_status;

  // -------------------------------------------------------------------------
  // Setup-phase capture: read data and RX availability
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_prdata   <= 8'h00;
      r_rx_avail <= 1'b0;
    end else if (w_setup_ph) begin
      r_prdata   <= w_rd_mux;
      r_rx_avail <= ~rx_empty;
    end
  end

  // -------------------------------------------------------------------------
  // Access-phase register updates
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ctrl    <= CTRL_RST;
      r_ier     <= 6'h00;
      r_baud_lo <= BAUD_DIV_RST[7:0];
      r_baud_hi <= BAUD_DIV_RST[15:8];
    end else begin
      if (w_wr_acc && w_sel_ctrl) r_ctrl    <= {3'b000, PWDATA[4:0]};
      if (w_wr_acc && w_sel_ier)  r_ier     <= PWDATA[5:0];
      if (w_wr_acc && w_sel_blo)  r_baud_lo <= PWDATA;
      if (w_wr_acc && w_sel_bhi)  r_baud_hi <= PWDATA;
    end
  end

  // Sticky flags: a set in the same cycle as a W1C clear takes priority.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tx_ovr <= 1'b0;
      r_rx_ovr <= 1'b0;
    end else begin
      r_tx_ovr <= w_tx_ovr_set | (r_tx_ovr & ~(w_sts_wr & PWDATA[4]));
      r_rx_ovr <= rx_overrun   | (r_rx_ovr & ~(w_sts_wr & PWDATA[5]));
    end
  end

  // -------------------------------------------------------------------------
  // Interrupt register
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_status[5:0] & r_ier);
    end
  end

  assign PRDATA   = r_prdata;
  assign PREADY   = 1'b1;
  // Gated by PRESETn so a transfer caught by reset never reports an error.
  assign PERROR   = PRESETn & (w_proto_err | w_xfer_err);
  assign tx_push  = w_push;
  assign tx_data  = PWDATA;
  assign rx_pop   = w_pop;
  assign ctrl     = r_ctrl;
  assign baud_div = {r_baud_hi, r_baud_lo};
  assign irq      = r_irq;

endmodule
